led_pattern_engine: RTL and testbench
=====================================

Name: led_pattern_engine

Overview:
Parametrised LED pattern controller that generalises the board's LED demo datapath into one block. It contains:
- a programmable tick prescaler
- four concurrently running pattern generators (flash, single shift, double shift, auto-bounce)
- a debounced, edge-triggered mode selector
- a one-hot colour-channel router driving NB_COLOR channels of NB_LEDS LEDs

It sits between the switch/button source mux (hardware or VIO) and the RGB LED pins/debug probes.

Parameters:
NB_LEDS, 4, LEDs per colour channel (>=3)
NB_COLOR, 3, number of colour channels (index 0=red, 1=green, 2=blue)
NB_COUNTER, 32, prescaler counter width
NB_SPEED, 3, width of speed-select input
BASE_PERIOD, 4, tick period in cycles at i_speed=0 (>=2)
DB_CYCLES, 3, cycles a button level must be stable before it is accepted (>=1)

Ports:
clock  input  1  system clock, all logic on rising edge
i_reset  input  1  synchronous active-low reset
i_speed  input  NB_SPEED  period select: period = BASE_PERIOD << i_speed cycles
i_pause  input  1  1 = freeze prescaler and all pattern registers
i_reverse  input  1  direction for SHIFT and SHIFT2 (0 = towards MSB)
i_mode_btn  input  1  mode-advance button, raw level
i_color_btn  input  NB_COLOR  colour-select buttons, one-hot
o_led  output  NB_COLOR*NB_LEDS  channel c occupies bits [c*NB_LEDS +: NB_LEDS]
o_mode  output  2  current mode (0 FLASH, 1 SHIFT, 2 SHIFT2, 3 BOUNCE)
o_color  output  $clog2(NB_COLOR)  active channel index
o_tick  output  1  registered prescaler tick, 1-cycle pulse

Behaviour:
Reset (i_reset=0 at a clock edge, overrides everything):
- counter=0, o_tick=0, o_mode=0, o_color=0
- flash=all-0, shift=0..01, shift2=0..011, bounce=0..01 with bounce direction=up
- debouncer state and stable level are loaded with the current i_mode_btn, so no spurious edge occurs on reset release
- o_led=0 during reset and on the first cycle after it

Prescaler:
- Counter increments each unpaused cycle.
- When counter >= period-1: counter←0 and o_tick←1 on that edge. Otherwise o_tick←0.
- The >= comparison means a speed reduction mid-count forces a wrap on the next cycle.
- Period computation is NB_COUNTER wide; overflow of the shift is a configuration error and is not checked.
- While i_pause=1: counter holds and o_tick=0.

Patterns:
- Every pattern register advances on each cycle where o_tick=1, regardless of the selected mode, so a mode switch shows that generator's current state.
- FLASH: register inverts (all-0 ↔ all-1).
- SHIFT: one-hot rotates left when i_reverse=0, right when 1; wraps MSB→LSB and LSB→MSB.
- SHIFT2: two adjacent ones rotate the same way as SHIFT, with wrap (e.g. 1001 is legal at NB_LEDS=4).
- BOUNCE: one-hot moves up to the MSB, then direction flips and it moves down to the LSB, then flips again. i_reverse is ignored. There is no dwell at the ends: 0100→1000→0100.

Mode select:
- The debouncer accepts a new i_mode_btn level only after it has differed from the stable level for DB_CYCLES consecutive cycles. The count restarts on any bounce.
- A 0→1 transition of the accepted level advances o_mode 0→1→2→3→0, visible on the next cycle.
- A held button produces only one advance.

Colour select:
- If i_color_btn has exactly one bit set, o_color←that index on the next edge. This takes effect even when paused.
- Zero or multiple bits set: o_color holds.

Output:
- o_led is registered, computed from the previous-cycle mode, colour and pattern.
- Channel o_color carries the selected pattern; all other channels are 0.
- Latency: tick edge → pattern update (+1) → o_led (+1).

Test Plan:
1. Reset release: NB_LEDS=4, i_speed=0, release reset with i_mode_btn=1 held → o_mode stays 0, o_tick pulses at cycles 3, 7, 11 after release, and red channel o_led toggles 0000/1111 two cycles after each tick.
2. Shift direction and speed: mode=1, i_reverse=0 → red channel 0001→0010→0100→1000→0001. Set i_reverse=1 → the next tick goes right. Set i_speed=2 → ticks every 16 cycles. Drop i_speed from 2 to 0 with counter=10 → tick on the next cycle.
3. Bounce: mode=3 from reset → 0001,0010,0100,1000,0100,0010,0001,0010 over successive ticks with i_reverse toggled randomly; SHIFT2 in the same run shows 0011→0110→1100→1001.
4. Debounce: i_mode_btn pulses 1 for 2 cycles (DB_CYCLES=3) → no mode change. Held 3+ cycles → exactly one advance. Four clean presses → o_mode returns to 0.
5. Colour routing: i_color_btn=010 → pattern on o_led[7:4], other channels 0. i_color_btn=011 or 000 → o_color holds at 1.
6. Pause and mid-operation reset: i_pause=1 for 50 cycles → o_tick=0 and o_led constant. Assert i_reset=0 in mode 2 with colour=2 → next cycle all outputs at reset values.

Source files
------------

// File: rtl/led_pattern_engine.sv
// LED pattern engine: tick prescaler, four free-running pattern generators,
// debounced mode selector and one-hot colour router feeding the RGB LED pins.
module led_pattern_engine #(
    parameter int NB_LEDS     = 4,
    parameter int NB_COLOR    = 3,
    parameter int NB_COUNTER  = 32,
    parameter int NB_SPEED    = 3,
    parameter int BASE_PERIOD = 4,
    parameter int DB_CYCLES   = 3
) (
    input  logic                         clock,
    input  logic                         i_reset,
    input  logic [NB_SPEED-1:0]          i_speed,
    input  logic                         i_pause,
    input  logic                         i_reverse,
    input  logic                         i_mode_btn,
    input  logic [NB_COLOR-1:0]          i_color_btn,
    output logic [NB_COLOR*NB_LEDS-1:0]  o_led,
    output logic [1:0]                   o_mode,
    output logic [$clog2(NB_COLOR)-1:0]  o_color,
    output logic                         o_tick
);

    localparam int NB_CSEL = $clog2(NB_COLOR);
    localparam int NB_DB   = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        MODE_FLASH  = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_SHIFT2 = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    mode_t                  mode_q;
    mode_t                  mode_d;
    logic [NB_COUNTER-1:0]  counter;
    logic [NB_COUNTER-1:0]  period;
    logic [NB_LEDS-1:0]     flash;
    logic [NB_LEDS-1:0]     shift;
    logic [NB_LEDS-1:0]     shift2;
    logic [NB_LEDS-1:0]     bounce;
    logic                   bounce_up;
    logic                   db_stable;
    logic [NB_DB-1:0]       db_count;
    logic                   db_accept;
    logic                   mode_rise;
    logic                   color_onehot;
    logic [NB_CSEL-1:0]     color_idx;
    logic [NB_LEDS-1:0]     pattern_sel;
    logic [NB_COLOR*NB_LEDS-1:0] led_next;

    assign period = NB_COUNTER'(BASE_PERIOD) << i_speed;

    // The >= compare lets a speed reduction mid-count wrap on the next cycle.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            counter <= '0;
            o_tick  <= 1'b0;
        end else if (i_pause) begin
            o_tick  <= 1'b0;
        end else if (counter >= period - NB_COUNTER'(1)) begin
            counter <= '0;
            o_tick  <= 1'b1;
        end else begin
            counter <= counter + NB_COUNTER'(1);
            o_tick  <= 1'b0;
        end
    end

    // All generators advance together so switching mode shows live state.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            flash     <= '0;
            shift     <= NB_LEDS'(1);
            shift2    <= NB_LEDS'(3);
            bounce    <= NB_LEDS'(1);
            bounce_up <= 1'b1;
        end else if (o_tick && !i_pause) begin
            flash <= ~flash;
            if (i_reverse) begin
                shift  <= {shift[0], shift[NB_LEDS-1:1]};
                shift2 <= {shift2[0], shift2[NB_LEDS-1:1]};
            end else begin
                shift  <= {shift[NB_LEDS-2:0], shift[NB_LEDS-1]};
                shift2 <= {shift2[NB_LEDS-2:0], shift2[NB_LEDS-1]};
            end
            if (bounce_up) begin
                if (bounce[NB_LEDS-1]) begin
                    bounce_up <= 1'b0;
                    bounce    <= bounce >> 1;
                end else begin
                    bounce    <= bounce << 1;
                end
            end else begin
                if (bounce[0]) begin
                    bounce_up <= 1'b1;
                    bounce    <= bounce << 1;
                end else begin
                    bounce    <= bounce >> 1;
                end
            end
        end
    end

    assign db_accept = (i_mode_btn != db_stable) && (db_count == NB_DB'(DB_CYCLES - 1));
    assign mode_rise = db_accept && i_mode_btn;

    // Stable level is preloaded from the pin so reset release cannot fake an edge.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            db_stable <= i_mode_btn;
            db_count  <= '0;
        end else if (i_mode_btn == db_stable) begin
            db_count  <= '0;
        end else if (db_accept) begin
            db_stable <= i_mode_btn;
            db_count  <= '0;
        end else begin
            db_count  <= db_count + NB_DB'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            mode_q <= MODE_FLASH;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_rise) begin
            case (mode_q)
                MODE_FLASH:  mode_d = MODE_SHIFT;
                MODE_SHIFT:  mode_d = MODE_SHIFT2;
                MODE_SHIFT2: mode_d = MODE_BOUNCE;
                default:     mode_d = MODE_FLASH;
            endcase
        end
    end

    assign o_mode = mode_q;

    always_comb begin
        color_onehot = (i_color_btn != '0) &&
                       ((i_color_btn & (i_color_btn - NB_COLOR'(1))) == '0);
        color_idx = '0;
        for (int c = 0; c < NB_COLOR; c++) begin
            if (i_color_btn[c]) begin
                color_idx = NB_CSEL'(c);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            o_color <= '0;
        end else if (color_onehot) begin
            o_color <= color_idx;
        end
    end

    always_comb begin
        pattern_sel = '0;
        case (mode_q)
            MODE_FLASH:  pattern_sel = flash;
            MODE_SHIFT:  pattern_sel = shift;
            MODE_SHIFT2: pattern_sel = shift2;
            default:     pattern_sel = bounce;
        endcase
        led_next = '0;
        for (int c = 0; c < NB_COLOR; c++) begin
            if (o_color == NB_CSEL'(c)) begin
                led_next[c*NB_LEDS +: NB_LEDS] = pattern_sel;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            o_led <= '0;
        end else begin
            o_led <= led_next;
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed scenarios plus random
// stimulus compared against a position-based behavioural model.
module tb_led_pattern_engine;

    localparam int NL = 4;
    localparam int NC = 3;
    localparam int DB = 3;

    logic          clock;
    logic          i_reset;
    logic [2:0]    i_speed;
    logic          i_pause;
    logic          i_reverse;
    logic          i_mode_btn;
    logic [NC-1:0] i_color_btn;
    logic [NC*NL-1:0] o_led;
    logic [1:0]    o_mode;
    logic [1:0]    o_color;
    logic          o_tick;

    int checks   = 0;
    int failures = 0;

    // Model state: patterns tracked as LED positions rather than bit vectors.
    int   m_cnt, m_mode, m_color, m_sp, m_s2, m_bp;
    bit   m_tick, m_flash, m_bup, m_stable;
    bit   m_hist[$];
    logic [NC*NL-1:0] m_led;

    led_pattern_engine #(
        .NB_LEDS(NL), .NB_COLOR(NC), .NB_COUNTER(32), .NB_SPEED(3),
        .BASE_PERIOD(4), .DB_CYCLES(DB)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_speed(i_speed), .i_pause(i_pause),
        .i_reverse(i_reverse), .i_mode_btn(i_mode_btn), .i_color_btn(i_color_btn),
        .o_led(o_led), .o_mode(o_mode), .o_color(o_color), .o_tick(o_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [NL-1:0] model_pattern();
        case (m_mode)
            0:       return m_flash ? 4'hF : 4'h0;
            1:       return 4'(1 << m_sp);
            2:       return 4'((1 << m_s2) | (1 << ((m_s2 + 1) % NL)));
            default: return 4'(1 << m_bp);
        endcase
    endfunction

    function automatic logic [NC*NL+4:0] model_outputs();
        return {m_led, 2'(m_mode), 2'(m_color), m_tick};
    endfunction

    // One clock edge: advance the model from the inputs seen at that edge.
    task automatic step();
        int ones;
        int idx;
        bit all_diff;
        @(posedge clock);
        if (!i_reset) begin
            m_cnt = 0; m_tick = 0; m_mode = 0; m_color = 0;
            m_flash = 0; m_sp = 0; m_s2 = 0; m_bp = 0; m_bup = 1;
            m_stable = i_mode_btn; m_hist.delete(); m_led = '0;
        end else begin
            m_led = '0;
            m_led[m_color*NL +: NL] = model_pattern();
            if (m_tick && !i_pause) begin
                m_flash = !m_flash;
                m_sp = i_reverse ? (m_sp + NL - 1) % NL : (m_sp + 1) % NL;
                m_s2 = i_reverse ? (m_s2 + NL - 1) % NL : (m_s2 + 1) % NL;
                if (m_bup) begin
                    if (m_bp == NL - 1) begin m_bup = 0; m_bp--; end else m_bp++;
                end else begin
                    if (m_bp == 0) begin m_bup = 1; m_bp++; end else m_bp--;
                end
            end
            if (i_pause) m_tick = 0;
            else if (m_cnt >= (4 << i_speed) - 1) begin m_cnt = 0; m_tick = 1; end
            else begin m_cnt++; m_tick = 0; end
            m_hist.push_back(i_mode_btn);
            while (m_hist.size() > DB) void'(m_hist.pop_front());
            all_diff = (m_hist.size() == DB);
            foreach (m_hist[k]) if (m_hist[k] == m_stable) all_diff = 0;
            if (all_diff) begin
                m_stable = i_mode_btn;
                m_hist.delete();
                if (m_stable) m_mode = (m_mode + 1) % 4;
            end
            ones = 0; idx = 0;
            for (int c = 0; c < NC; c++) if (i_color_btn[c]) begin ones++; idx = c; end
            if (ones == 1) m_color = idx;
        end
        #1;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin step(); n++; end while (o_tick !== 1'b1 && n < 200);
        if (o_tick !== 1'b1) begin
            checks++; failures++;
            $display("[TB] FAIL tick_timeout: no o_tick within %0d cycles", n);
        end
    endtask

    task automatic press_mode(int hold);
        i_mode_btn = 1'b1; repeat (hold) step();
        i_mode_btn = 1'b0; repeat (hold) step();
    endtask

    // Fresh reset, then select a mode while paused so patterns start from reset.
    task automatic start_mode(int presses);
        i_reset = 0; i_pause = 1; i_mode_btn = 0; i_reverse = 0;
        i_color_btn = '0; i_speed = 0;
        step(); step();
        i_reset = 1;
        repeat (presses) press_mode(4);
        i_pause = 0;
    endtask

    task automatic test_reset();
        i_reset = 0; i_speed = 0; i_pause = 0; i_reverse = 0;
        i_mode_btn = 1; i_color_btn = '0;
        repeat (3) step();
        checks++;
        if ({o_led, o_mode, o_color, o_tick} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h required 0", {o_led, o_mode, o_color, o_tick});
        end
        i_reset = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (o_tick !== ((i == 3) || (i == 7) || (i == 11) || (i == 15))) begin
                failures++;
                $display("[TB] FAIL reset_tick_c%0d: got %b", i, o_tick);
            end
            checks++;
            if ({o_led, o_mode, o_color, o_tick} !== model_outputs()) begin
                failures++;
                $display("[TB] FAIL reset_model_c%0d: got %h required %h", i,
                         {o_led, o_mode, o_color, o_tick}, model_outputs());
            end
        end
        checks++;
        if (o_mode !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_mode_held_btn: got %0d required 0", o_mode);
        end
    endtask

    task automatic test_shift();
        logic [NL-1:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int n;
        start_mode(1);
        checks++;
        if (o_led[NL-1:0] !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL shift_initial: got %b required 0001", o_led[NL-1:0]);
        end
        foreach (exp_seq[k]) begin
            wait_tick(); step(); step();
            checks++;
            if (o_led[NL-1:0] !== exp_seq[k]) begin
                failures++;
                $display("[TB] FAIL shift_left_%0d: got %b required %b", k, o_led[NL-1:0], exp_seq[k]);
            end
        end
        i_reverse = 1;
        wait_tick(); step(); step();
        checks++;
        if (o_led[NL-1:0] !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL shift_reverse: got %b required 1000", o_led[NL-1:0]);
        end
        i_speed = 2;
        wait_tick();
        n = 0;
        do begin step(); n++; end while (o_tick !== 1'b1 && n < 100);
        checks++;
        if (n !== 16) begin
            failures++;
            $display("[TB] FAIL speed2_period: got %0d required 16", n);
        end
        repeat (10) step();
        checks++;
        if (o_tick !== 1'b0) begin
            failures++;
            $display("[TB] FAIL speed_drop_early: got %b required 0", o_tick);
        end
        i_speed = 0;
        step();
        checks++;
        if (o_tick !== 1'b1) begin
            failures++;
            $display("[TB] FAIL speed_drop_wrap: got %b required 1", o_tick);
        end
        checks++;
        if ({o_led, o_mode, o_color, o_tick} !== model_outputs()) begin
            failures++;
            $display("[TB] FAIL shift_model: got %h required %h", {o_led, o_mode, o_color, o_tick}, model_outputs());
        end
    endtask

    task automatic test_bounce();
        logic [NL-1:0] b_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        logic [NL-1:0] s_seq [3] = '{4'b0110, 4'b1100, 4'b1001};
        start_mode(3);
        checks++;
        if (o_led !== 12'h001) begin
            failures++;
            $display("[TB] FAIL bounce_initial: got %h required 001", o_led);
        end
        foreach (b_seq[k]) begin
            i_reverse = 1'($urandom_range(0, 1));
            wait_tick(); step(); step();
            checks++;
            if (o_led !== {8'h00, b_seq[k]}) begin
                failures++;
                $display("[TB] FAIL bounce_%0d: got %h required %h", k, o_led, {8'h00, b_seq[k]});
            end
        end
        start_mode(2);
        checks++;
        if (o_led[NL-1:0] !== 4'b0011) begin
            failures++;
            $display("[TB] FAIL shift2_initial: got %b required 0011", o_led[NL-1:0]);
        end
        foreach (s_seq[k]) begin
            wait_tick(); step(); step();
            checks++;
            if (o_led[NL-1:0] !== s_seq[k]) begin
                failures++;
                $display("[TB] FAIL shift2_%0d: got %b required %b", k, o_led[NL-1:0], s_seq[k]);
            end
        end
    endtask

    task automatic test_debounce();
        logic [1:0] m0;
        m0 = o_mode;
        i_mode_btn = 1; repeat (2) step();
        i_mode_btn = 0; repeat (5) step();
        checks++;
        if (o_mode !== m0) begin
            failures++;
            $display("[TB] FAIL debounce_glitch: got %0d required %0d", o_mode, m0);
        end
        i_mode_btn = 1; repeat (8) step();
        checks++;
        if (o_mode !== 2'(m0 + 1)) begin
            failures++;
            $display("[TB] FAIL debounce_single_advance: got %0d required %0d", o_mode, 2'(m0 + 1));
        end
        i_mode_btn = 0; repeat (4) step();
        repeat (3) press_mode(5);
        checks++;
        if (o_mode !== m0) begin
            failures++;
            $display("[TB] FAIL debounce_wrap: got %0d required %0d", o_mode, m0);
        end
        checks++;
        if ({o_led, o_mode, o_color, o_tick} !== model_outputs()) begin
            failures++;
            $display("[TB] FAIL debounce_model: got %h required %h", {o_led, o_mode, o_color, o_tick}, model_outputs());
        end
    endtask

    task automatic test_color();
        i_color_btn = 3'b010; step();
        i_color_btn = 3'b000; repeat (3) step();
        checks++;
        if (o_color !== 2'd1) begin
            failures++;
            $display("[TB] FAIL color_select: got %0d required 1", o_color);
        end
        checks++;
        if (o_led[3:0] !== 4'h0 || o_led[11:8] !== 4'h0 || o_led !== m_led) begin
            failures++;
            $display("[TB] FAIL color_route: got %h required %h", o_led, m_led);
        end
        i_color_btn = 3'b011; repeat (2) step();
        checks++;
        if (o_color !== 2'd1) begin
            failures++;
            $display("[TB] FAIL color_multi_hold: got %0d required 1", o_color);
        end
        i_color_btn = 3'b000; repeat (2) step();
        checks++;
        if (o_color !== 2'd1) begin
            failures++;
            $display("[TB] FAIL color_zero_hold: got %0d required 1", o_color);
        end
    endtask

    task automatic test_pause();
        logic [NC*NL-1:0] held;
        i_pause = 1; step(); step();
        held = o_led;
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if (o_tick !== 1'b0 || o_led !== held) begin
                failures++;
                $display("[TB] FAIL pause_c%0d: tick %b led %h required tick 0 led %h", i, o_tick, o_led, held);
            end
        end
        i_pause = 0;
    endtask

    task automatic test_midreset();
        start_mode(2);
        i_color_btn = 3'b100; step();
        i_color_btn = 3'b000; repeat (10) step();
        checks++;
        if (o_mode !== 2'd2 || o_color !== 2'd2) begin
            failures++;
            $display("[TB] FAIL midreset_setup: mode %0d color %0d required 2 2", o_mode, o_color);
        end
        i_reset = 0; step();
        checks++;
        if ({o_led, o_mode, o_color, o_tick} !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_values: got %h required 0", {o_led, o_mode, o_color, o_tick});
        end
        i_reset = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            i_reset     = ($urandom_range(0, 299) != 0);
            i_pause     = ($urandom_range(0, 7) == 0);
            i_reverse   = 1'($urandom_range(0, 1));
            i_speed     = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) i_mode_btn = !i_mode_btn;
            i_color_btn = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
            step();
            checks++;
            if ({o_led, o_mode, o_color, o_tick} !== model_outputs()) begin
                failures++;
                $display("[TB] FAIL random_c%0d: got %h required %h", i,
                         {o_led, o_mode, o_color, o_tick}, model_outputs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_bounce();
        test_debounce();
        test_color();
        test_pause();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
